// File: rtl/regfile_write_demux.sv
// Write side of the 16 x 32 register bank: 1-to-16 write demux, register storage and a clear-all sequencer.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero (writes to address 0 are accepted but discarded).
module regfile_write_demux #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [NREG-1:0]         wr_sel,
  output logic                    wr_done,
  input  logic                    clr_req,
  output logic                    busy,
  output logic [NREG*WIDTH-1:0]   q_flat
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          wr_fire;

  // A pending clear request takes priority over a write in the same cycle.
  assign wr_ready = (state == IDLE) && !clr_req;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    wr_sel = '0;
    wr_sel[wr_addr] = wr_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= wr_fire;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter wraps to 0 on the same edge the sequencer returns to IDLE.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(NREG - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic [WIDTH-1:0] reg_q;

    if (R0_ZERO && (i == 0)) begin : g_zero
      assign reg_q = '0;
    end else begin : g_flop
      logic clr_hit;
      assign clr_hit = (state == CLEAR) && (clr_cnt == AW'(i));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else if (clr_hit) begin
          reg_q <= '0;
        end else if (wr_sel[i]) begin
          reg_q <= wr_data;
        end
      end
    end

    assign q_flat[WIDTH*i +: WIDTH] = reg_q;
  end

endmodule

// File: tb/tb_regfile_write_demux.sv
// Randomized scoreboard bench for regfile_write_demux; honours REGFILE_R0_ZERO_EN when defined.
module tb_regfile_write_demux;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [15:0]  wr_sel;
  logic         wr_done;
  logic         clr_req;
  logic         busy;
  logic [511:0] q_flat;

  regfile_write_demux #(.WIDTH(32), .NREG(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_sel(wr_sel), .wr_done(wr_done), .clr_req(clr_req), .busy(busy), .q_flat(q_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: register contents plus the index the clear will wipe next (-1 when not clearing).
  logic [31:0] model_regs [16];
  int          clr_pos;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    clr_pos = -1;
  endtask

  // One clock cycle: drive inputs just after a falling edge, check the combinational
  // outputs, advance the model across the rising edge, then check state at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [31:0] d, input logic c);
    logic        exp_ready;
    logic        exp_accept;
    logic [15:0] exp_sel;
    sb_entry_t   e;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    clr_req  = c;
    #1;
    exp_ready  = (clr_pos < 0) && !c;
    exp_accept = v && exp_ready;
    exp_sel    = exp_accept ? (16'h1 << a) : 16'h0;
    checkOutput("wr_ready", 512'(wr_ready), 512'(exp_ready));
    checkOutput("wr_sel", 512'(wr_sel), 512'(exp_sel));
    if (exp_accept) begin
      e.addr = int'(a);
      e.data = (R0_ZERO && a == 4'd0) ? 32'h0 : d;
      sb_q.push_back(e);
      model_regs[a] = e.data;
    end
    if (clr_pos >= 0) begin
      model_regs[clr_pos] = '0;
      clr_pos++;
      if (clr_pos == 16) clr_pos = -1;
    end else if (c) begin
      clr_pos = 0;
    end
    @(negedge clk);
    checkOutput("q_flat", q_flat, model_flat());
    checkOutput("busy", 512'(busy), 512'(clr_pos >= 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), $urandom, 1'b0);
  endtask

  // Monitor: every wr_done must match the oldest accepted write, and the written value must be visible.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wr_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("wr_done_unexpected", 512'(1), 512'(0));
        end else begin
          e = sb_q.pop_front();
          checkOutput($sformatf("wr_data_at_done[%0d]", e.addr), 512'(q_flat[32*e.addr +: 32]), 512'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset_q_flat", q_flat, 512'(0));
    checkOutput("reset_busy", 512'(busy), 512'(0));
    checkOutput("reset_wr_done", 512'(wr_done), 512'(0));
    checkOutput("reset_wr_ready", 512'(wr_ready), 512'(1));
    rst_n = 1'b1;

    $display("[TB] single write to address 5");
    applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
    checkOutput("addr5_slice", 512'(q_flat[191:160]), 512'(32'hDEADBEEF));
    idle(1);

    $display("[TB] back-to-back writes to all addresses");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 32'h1000_0000 + 32'(i), 1'b0);
    idle(1);
    checkOutput("addr15_slice", 512'(q_flat[511:480]), 512'(32'h1000_000F));

    $display("[TB] repeat writes to one address");
    applyStimulus(1'b1, 4'd7, 32'h1111_1111, 1'b0);
    applyStimulus(1'b1, 4'd7, 32'h2222_2222, 1'b0);
    idle(1);
    checkOutput("addr7_last_wins", 512'(q_flat[255:224]), 512'(32'h2222_2222));

    $display("[TB] clear with writes attempted while busy");
    load_all();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
    idle(2);
    checkOutput("cleared_all", q_flat, 512'(0));

    $display("[TB] write and clear request in the same cycle");
    load_all();
    applyStimulus(1'b1, 4'd3, 32'hA5A5A5A5, 1'b1);
    idle(17);
    checkOutput("addr3_after_clear", 512'(q_flat[127:96]), 512'(0));

    $display("[TB] reset during a clear");
    load_all();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
    idle(6);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midclear_reset_q_flat", q_flat, 512'(0));
    checkOutput("midclear_reset_busy", 512'(busy), 512'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd9, 32'h12345678, 1'b0);
    checkOutput("addr9_after_reset", 512'(q_flat[319:288]), 512'(32'h12345678));
    idle(1);

    $display("[TB] write to address 0");
    applyStimulus(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0);
    checkOutput("addr0_slice", 512'(q_flat[31:0]), 512'(R0_ZERO ? 32'h0 : 32'hFFFFFFFF));
    idle(1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), 4'($urandom), $urandom, 1'($urandom_range(0, 39) == 0));
    idle(20);

    checkOutput("scoreboard_empty", 512'(sb_q.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_demux.md
Name: regfile_write_demux

Overview:
- Write side of the 16-entry x 32-bit register bank whose read side is the 16-to-1 32-bit mux.
- Decodes a 4-bit write address into one-hot register enables (1-to-16 demux) and holds the 16 registers.
- Accepts writes over a valid/ready handshake and runs a multi-cycle clear-all sequencer.
- Exposes all register contents flattened so the read mux can select any entry.

Parameters:
- WIDTH, 32, data width of each register
- NREG, 16, number of registers; fixed at 16 for this bank
- AW, 4, address width; AW = log2(NREG)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_valid  input  1  write request valid
- wr_ready  output  1  block can accept a write this cycle
- wr_addr  input  AW  destination register index
- wr_data  input  WIDTH  write data
- wr_sel  output  NREG  combinational one-hot decode of wr_addr, gated by (wr_valid && wr_ready)
- wr_done  output  1  registered pulse, one cycle after a write is accepted
- clr_req  input  1  request to clear all registers
- busy  output  1  high while the clear sequence runs
- q_flat  output  NREG*WIDTH  register i drives q_flat[WIDTH*i +: WIDTH]

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0, state IDLE, clear counter 0
  - wr_done 0, busy 0
  - wr_ready follows its combinational equation, so it is high when clr_req is 0
- States: IDLE, CLEAR.
- wr_ready = (state == IDLE) && !clr_req. A pending clear has priority over a write.
- Write acceptance: wr_valid && wr_ready at a rising edge.
  - register wr_addr loads wr_data
  - new value visible on q_flat the next cycle (latency 1)
  - wr_done high for exactly that next cycle
- wr_sel: exactly one bit set when a write is accepted, else all zero. Bit index equals wr_addr.
- Back-to-back writes: one per cycle; wr_done pulses on consecutive cycles.
- Repeat writes to the same address in consecutive cycles: the last write wins.
- Holding wr_valid while wr_ready is low: no state change, no wr_done. wr_addr and wr_data may change freely.
- IDLE -> CLEAR when clr_req = 1. Counter is set to 0 and busy rises the next cycle.
- In CLEAR:
  - each cycle, register[counter] <= 0 and counter increments
  - when counter == NREG-1, that register is cleared, state -> IDLE, busy falls
  - busy is high for exactly NREG cycles
- Registers not yet reached by the counter keep their values, so the clear is observable progressively on q_flat.
- clr_req while in CLEAR is ignored; no restart.
- clr_req held high in IDLE after a clear completes starts a new clear immediately.
- Reset mid-clear: immediate return to IDLE with all registers 0; no partial sequence resumes.
- Counter is AW bits wide. Wrap from NREG-1 to 0 coincides with the exit to IDLE.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - register 0 is hardwired to 0 and q_flat[WIDTH-1:0] is constant 0
  - writes to address 0 are still accepted (wr_ready, wr_sel[0], wr_done behave normally) but data is discarded
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset, then write addr 5 data 0xDEADBEEF -> wr_sel = 0x0020 in the accept cycle; next cycle q_flat[191:160] = 0xDEADBEEF, wr_done = 1 for one cycle, all other slices 0.
- Write all 16 addresses back-to-back with data = 0x1000_0000+i -> 16 consecutive wr_done pulses; each slice i equals 0x1000_0000+i.
- Load all registers, pulse clr_req for one cycle -> busy high exactly 16 cycles; register k reads 0 starting k+1 cycles after busy rises; wr_ready low throughout; wr_valid writes during busy are ignored.
- Same cycle wr_valid=1 (addr 3, 0xA5A5A5A5) and clr_req=1 in IDLE -> write not accepted, wr_done stays 0, clear runs, register 3 ends at 0.
- Assert rst_n low at cycle 7 of a clear -> all of q_flat 0 and busy 0 immediately. After release, a write to addr 9 of 0x12345678 succeeds with 1-cycle latency.
- With REGFILE_R0_ZERO_EN: write addr 0 data 0xFFFFFFFF -> wr_done pulses, q_flat[31:0] stays 0. Without the macro the same write reads back 0xFFFFFFFF.
